systolic_ws_fi_array: RTL and testbench

//  Weight-stationary ROWS x COLS systolic MAC array with a built-in run controller and a run-time fault injector.

---
 rtl/systolic_ws_fi_array.sv | 267 ++++++++++++++++++++++++++
 tb/tb_systolic_ws_fi_array.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ws_fi_array.sv
// Weight-stationary ROWS x COLS MAC array with run controller and per-run fault injector.
// Latency ROWS+COLS cycles from activation handshake to out_valid; outputs have no backpressure.
module systolic_ws_fi_array #(
    parameter int D_W   = 8,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int VEC_W = 8,
    localparam int ACC_W = 2*D_W + $clog2(ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  skip_load,
    input  logic [VEC_W-1:0]      num_vec,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [COLS*D_W-1:0]   w_data,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ROWS*D_W-1:0]   a_data,
    output logic                  out_valid,
    output logic [COLS*ACC_W-1:0] out_data,
    output logic                  busy,
    output logic                  done,
    input  logic                  fi_en,
    input  logic [7:0]            fi_row,
    input  logic [7:0]            fi_col,
    input  logic [1:0]            fi_target,
    input  logic [1:0]            fi_mode,
    input  logic [ACC_W-1:0]      fi_mask,
    output logic [15:0]           fi_hits
);
    localparam int SK_N = (ROWS*(ROWS-1))/2;
    localparam int DS_N = (COLS*(COLS-1))/2;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [VEC_W-1:0]   cnt, num_vec_q;
    logic               fi_en_q;
    logic [7:0]         fi_row_q, fi_col_q;
    logic [1:0]         fi_tgt_q, fi_mode_q;
    logic [ACC_W-1:0]   fi_mask_q;
    logic               fault_on, inj_vld, w_hs, any_tok;

    logic [D_W-1:0]     w_q      [ROWS][COLS];
    logic [D_W-1:0]     w_eff    [ROWS][COLS];
    logic [D_W-1:0]     act_eff  [ROWS][COLS];
    logic [ACC_W-1:0]   psum_eff [ROWS][COLS];
    logic               act_vld  [ROWS][COLS];
    logic               psum_vld [ROWS][COLS];
    logic [D_W-1:0]     inj_dat  [ROWS];
    logic [D_W-1:0]     skew_dat [SK_N];
    logic               skew_vld [SK_N];
    logic [ACC_W-1:0]   dsk_dat  [DS_N];
    logic               dsk_vld  [COLS-1];
    logic [ACC_W-1:0]   col_out  [COLS];
    logic [ROWS*COLS-1:0] hit_vec;

    function automatic logic [ACC_W-1:0] apply_fault(input logic [ACC_W-1:0] v,
                                                     input logic [1:0] mode,
                                                     input logic [ACC_W-1:0] m);
        case (mode)
            2'd0:    return v ^ m;
            2'd1:    return v & ~m;
            2'd2:    return v | m;
            default: return v;
        endcase
    endfunction

    assign busy     = (state != IDLE);
    assign inj_vld  = a_valid && a_ready;
    assign w_hs     = w_valid && w_ready;
    assign fault_on = fi_en_q && (fi_row_q < 8'(ROWS)) && (fi_col_q < 8'(COLS))
                      && (fi_tgt_q != 2'd3) && (fi_mode_q != 2'd3);

    always_comb begin
        state_nxt = state;
        w_ready   = 1'b0;
        a_ready   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = skip_load ? COMPUTE : LOAD;
            LOAD: begin
                w_ready = 1'b1;
                if (w_valid && cnt == VEC_W'(ROWS-1)) state_nxt = COMPUTE;
            end
            COMPUTE: begin
                a_ready = (cnt != num_vec_q);
                if (cnt == num_vec_q || (a_valid && a_ready && cnt + VEC_W'(1) == num_vec_q))
                    state_nxt = DRAIN;
            end
            DRAIN: if (!any_tok) begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            num_vec_q <= '0;
            fi_en_q   <= 1'b0;
            fi_row_q  <= '0;
            fi_col_q  <= '0;
            fi_tgt_q  <= '0;
            fi_mode_q <= '0;
            fi_mask_q <= '0;
            fi_hits   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)   cnt <= '0;
            else if (w_hs || inj_vld) cnt <= cnt + VEC_W'(1);
            if (state == IDLE && start) begin
                num_vec_q <= num_vec;
                fi_en_q   <= fi_en;
                fi_row_q  <= fi_row;
                fi_col_q  <= fi_col;
                fi_tgt_q  <= fi_target;
                fi_mode_q <= fi_mode;
                fi_mask_q <= fi_mask;
                fi_hits   <= '0;
            end else if (|hit_vec && fi_hits != 16'hFFFF) begin
                fi_hits <= fi_hits + 16'd1;
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_inj
        assign inj_dat[r] = inj_vld ? a_data[r*D_W +: D_W] : '0;
    end

    // Row r reaches column 0 through r skew stages, packed triangularly.
    for (genvar r = 1; r < ROWS; r++) begin : g_skew
        for (genvar k = 0; k < r; k++) begin : g_stage
            localparam int IDX = (r*(r-1))/2 + k;
            logic [D_W-1:0] d_in, d_r;
            logic           v_in, v_r;
            if (k == 0) begin : g_first
                assign d_in = inj_dat[r];
                assign v_in = inj_vld;
            end else begin : g_next
                assign d_in = skew_dat[IDX-1];
                assign v_in = skew_vld[IDX-1];
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    d_r <= '0;
                    v_r <= 1'b0;
                end else begin
                    d_r <= d_in;
                    v_r <= v_in;
                end
            end
            assign skew_dat[IDX] = d_r;
            assign skew_vld[IDX] = v_r;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic             hit, vld_in, vld_r, pvld_r;
            logic [D_W-1:0]   w_src, w_r, act_in, act_r;
            logic [ACC_W-1:0] psum_in, psum_r;

            assign hit = fault_on && fi_row_q == 8'(r) && fi_col_q == 8'(c);
            if (r == 0) begin : g_top
                assign w_src   = w_data[c*D_W +: D_W];
                assign psum_in = '0;
            end else begin : g_below
                assign w_src   = w_q[r-1][c];
                assign psum_in = psum_eff[r-1][c];
            end
            if (c > 0) begin : g_right
                assign act_in = act_eff[r][c-1];
                assign vld_in = act_vld[r][c-1];
            end else if (r == 0) begin : g_direct
                assign act_in = inj_dat[0];
                assign vld_in = inj_vld;
            end else begin : g_skewed
                assign act_in = skew_dat[(r*(r-1))/2 + r-1];
                assign vld_in = skew_vld[(r*(r-1))/2 + r-1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    w_r    <= '0;
                    act_r  <= '0;
                    vld_r  <= 1'b0;
                    psum_r <= '0;
                    pvld_r <= 1'b0;
                end else begin
                    if (w_hs) w_r <= w_src;
                    act_r  <= act_in;
                    vld_r  <= vld_in;
                    psum_r <= psum_in + ACC_W'(act_eff[r][c]) * ACC_W'(w_eff[r][c]);
                    pvld_r <= vld_r;
                end
            end

            // Faults corrupt what consumers see, never the stored register contents.
            assign w_q[r][c]      = w_r;
            assign w_eff[r][c]    = (hit && fi_tgt_q == 2'd0) ?
                                    D_W'(apply_fault(ACC_W'(w_r), fi_mode_q, fi_mask_q)) : w_r;
            assign act_eff[r][c]  = (hit && fi_tgt_q == 2'd1) ?
                                    D_W'(apply_fault(ACC_W'(act_r), fi_mode_q, fi_mask_q)) : act_r;
            assign psum_eff[r][c] = (hit && fi_tgt_q == 2'd2) ?
                                    apply_fault(psum_r, fi_mode_q, fi_mask_q) : psum_r;
            assign act_vld[r][c]  = vld_r;
            assign psum_vld[r][c] = pvld_r;
            assign hit_vec[r*COLS+c] = hit && vld_r;
        end
    end

    for (genvar c = 0; c < COLS-1; c++) begin : g_dsk
        localparam int DEP = COLS-1-c;
        localparam int B   = (DEP*(DEP-1))/2;
        for (genvar k = 0; k < DEP; k++) begin : g_stage
            logic [ACC_W-1:0] d_in, d_r;
            if (k == 0) begin : g_first
                assign d_in = psum_eff[ROWS-1][c];
            end else begin : g_next
                assign d_in = dsk_dat[B+k-1];
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) d_r <= '0;
                else     d_r <= d_in;
            end
            assign dsk_dat[B+k] = d_r;
        end
        assign col_out[c] = dsk_dat[B+DEP-1];
    end
    assign col_out[COLS-1] = psum_eff[ROWS-1][COLS-1];

    // Column 0 has the longest de-skew path, so its token alone marks the output wavefront.
    for (genvar k = 0; k < COLS-1; k++) begin : g_dsk_vld
        logic v_r;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)         v_r <= 1'b0;
            else if (k == 0) v_r <= psum_vld[ROWS-1][0];
            else             v_r <= dsk_vld[k-1 < 0 ? 0 : k-1];
        end
        assign dsk_vld[k] = v_r;
    end

    always_comb begin
        any_tok = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                any_tok = any_tok | act_vld[r][c] | psum_vld[r][c];
        for (int i = 0; i < SK_N; i++)   any_tok = any_tok | skew_vld[i];
        for (int k = 0; k < COLS-1; k++) any_tok = any_tok | dsk_vld[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= dsk_vld[COLS-2];
            for (int c = 0; c < COLS; c++) out_data[c*ACC_W +: ACC_W] <= col_out[c];
        end
    end
endmodule

// File: tb/tb_systolic_ws_fi_array.sv
// Bench for systolic_ws_fi_array: directed runs, expected vectors queued at handshake,
// a negedge monitor pops and checks data and arrival cycle for every out_valid.
module tb_systolic_ws_fi_array;
    localparam int D_W = 8, ROWS = 4, COLS = 4, VEC_W = 8, ACC_W = 18;
    localparam int LAT = ROWS + COLS;

    logic                  clk = 1'b0;
    logic                  rst, start, skip_load;
    logic [VEC_W-1:0]      num_vec;
    logic                  w_valid, w_ready, a_valid, a_ready;
    logic [COLS*D_W-1:0]   w_data;
    logic [ROWS*D_W-1:0]   a_data;
    logic                  out_valid, busy, done;
    logic [COLS*ACC_W-1:0] out_data;
    logic                  fi_en;
    logic [7:0]            fi_row, fi_col;
    logic [1:0]            fi_target, fi_mode;
    logic [ACC_W-1:0]      fi_mask;
    logic [15:0]           fi_hits;

    systolic_ws_fi_array dut (
        .clk(clk), .rst(rst), .start(start), .skip_load(skip_load), .num_vec(num_vec),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done),
        .fi_en(fi_en), .fi_row(fi_row), .fi_col(fi_col), .fi_target(fi_target),
        .fi_mode(fi_mode), .fi_mask(fi_mask), .fi_hits(fi_hits)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, passed = 0;

    typedef struct {
        logic [COLS*ACC_W-1:0] dat;
        int                    due;
    } exp_t;
    exp_t sb[$];

    bit watch_w = 1'b0, w_seen = 1'b0, saw_done;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    endtask

    function automatic logic [ROWS*D_W-1:0] pk4(input logic [7:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    function automatic logic [COLS*ACC_W-1:0] po4(input logic [ACC_W-1:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (watch_w && w_ready) w_seen = 1'b1;
        if (out_valid) begin
            if (sb.size() == 0) chk("unexpected_out", out_valid, 1'b0);
            else begin
                e = sb.pop_front();
                chk("out_data", out_data, e.dat);
                chk("out_latency", cyc, e.due);
            end
        end
    end

    task automatic start_run(input logic skip, input logic [7:0] nv, input logic fen,
                             input logic [7:0] frow, fcol, input logic [1:0] ftgt, fmode,
                             input logic [ACC_W-1:0] fmask);
        skip_load = skip; num_vec = nv; fi_en = fen; fi_row = frow; fi_col = fcol;
        fi_target = ftgt; fi_mode = fmode; fi_mask = fmask; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fi_en = 1'b0; fi_mask = '0; fi_row = 8'd0; fi_col = 8'd0;
    endtask

    task automatic send_w(input logic [COLS*D_W-1:0] row);
        bit ok = 1'b0;
        w_data = row; w_valid = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = w_ready;
        end
        if (!ok) chk("w_ready_timeout", w_ready, 1'b1);
        @(posedge clk); #1;
        w_valid = 1'b0;
    endtask

    task automatic send_a(input logic [ROWS*D_W-1:0] vec, input logic [COLS*ACC_W-1:0] want,
                          input bit push);
        bit ok = 1'b0;
        exp_t e;
        a_data = vec; a_valid = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = a_ready;
        end
        if (!ok) chk("a_ready_timeout", a_ready, 1'b1);
        else if (push) begin
            e.dat = want;
            e.due = cyc + 1 + LAT;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        a_valid = 1'b0; a_data = '0;
    endtask

    task automatic load_identity();
        send_w(pk4(0, 0, 0, 1));
        send_w(pk4(0, 0, 1, 0));
        send_w(pk4(0, 1, 0, 0));
        send_w(pk4(1, 0, 0, 0));
    endtask

    task automatic wait_done(input logic [15:0] hits_exp);
        bit seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            seen = done;
        end
        if (seen) begin
            chk("done_with_out", out_valid, 1'b1);
            chk("fi_hits", fi_hits, hits_exp);
        end else chk("done_timeout", done, 1'b1);
        @(posedge clk); #1;
        chk("idle_after_done", busy, 1'b0);
        chk("sb_empty", sb.size(), 0);
    endtask

    logic [31:0] vt  [5] = '{32'h04030201, 32'h00FF0001, 32'h11223344, 32'hFFFEFDFC, 32'h05000007};
    int          gap [5] = '{0, 3, 1, 2, 0};

    initial begin
        rst = 1'b1; start = 1'b0; skip_load = 1'b0; num_vec = '0;
        w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
        fi_en = 1'b0; fi_row = '0; fi_col = '0; fi_target = 2'd3; fi_mode = 2'd3; fi_mask = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_done", done, 1'b0);
        chk("rst_w_ready", w_ready, 1'b0);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_fi_hits", fi_hits, 16'd0);
        @(posedge clk); #1;

        // identity weights, no fault
        start_run(1'b0, 8'd1, 1'b0, 8'd0, 8'd0, 2'd3, 2'd3, '0);
        load_identity();
        send_a(pk4(1, 2, 3, 4), po4(1, 2, 3, 4), 1'b1);
        wait_done(16'd0);

        // W(0,0) bit-flip on resident identity
        start_run(1'b1, 8'd1, 1'b1, 8'd0, 8'd0, 2'd0, 2'd0, 18'h00001);
        send_a(pk4(1, 2, 3, 4), po4(0, 2, 3, 4), 1'b1);
        wait_done(16'd1);

        // all-ones weights, psum(3,2) stuck-1 on an already-set bit
        start_run(1'b0, 8'd1, 1'b1, 8'd3, 8'd2, 2'd2, 2'd2, 18'h08000);
        repeat (4) send_w(pk4(8'hFF, 8'hFF, 8'hFF, 8'hFF));
        send_a(pk4(8'hFF, 8'hFF, 8'hFF, 8'hFF), po4(18'h3F804, 18'h3F804, 18'h3F804, 18'h3F804), 1'b1);
        wait_done(16'd1);

        // same weights, psum(3,2) stuck-0 on bit 2
        start_run(1'b1, 8'd1, 1'b1, 8'd3, 8'd2, 2'd2, 2'd1, 18'h00004);
        send_a(pk4(8'hFF, 8'hFF, 8'hFF, 8'hFF), po4(18'h3F804, 18'h3F804, 18'h3F800, 18'h3F804), 1'b1);
        wait_done(16'd1);

        // five vectors with gaps; a start pulse mid-run must be ignored
        start_run(1'b0, 8'd5, 1'b0, 8'd0, 8'd0, 2'd3, 2'd3, '0);
        load_identity();
        for (int i = 0; i < 5; i++) begin
            send_a(vt[i], po4(vt[i][7:0], vt[i][15:8], vt[i][23:16], vt[i][31:24]), 1'b1);
            repeat (gap[i]) begin
                start = (i == 1); skip_load = 1'b1; num_vec = 8'd0;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        wait_done(16'd0);

        // reset mid-COMPUTE: aborts without done and clears weights
        start_run(1'b1, 8'd2, 1'b0, 8'd0, 8'd0, 2'd3, 2'd3, '0);
        send_a(pk4(1, 1, 1, 1), '0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_out_valid", out_valid, 1'b0);
        saw_done = done;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        chk("abort_no_done", saw_done, 1'b0);
        @(posedge clk); #1;
        start_run(1'b1, 8'd1, 1'b0, 8'd0, 8'd0, 2'd3, 2'd3, '0);
        send_a(pk4(5, 6, 7, 8), po4(0, 0, 0, 0), 1'b1);
        wait_done(16'd0);

        // load identity, then reuse it with skip_load while a busy start is ignored
        start_run(1'b0, 8'd1, 1'b0, 8'd0, 8'd0, 2'd3, 2'd3, '0);
        load_identity();
        send_a(pk4(1, 1, 1, 1), po4(1, 1, 1, 1), 1'b1);
        wait_done(16'd0);
        start_run(1'b1, 8'd1, 1'b0, 8'd0, 8'd0, 2'd3, 2'd3, '0);
        watch_w = 1'b1; w_seen = 1'b0;
        start = 1'b1; skip_load = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        send_a(pk4(9, 8, 7, 6), po4(9, 8, 7, 6), 1'b1);
        wait_done(16'd0);
        watch_w = 1'b0;
        chk("skip_load_w_ready", w_seen, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
